// File: rtl/icache_dm.sv
`timescale 1ns/1ps
// icache_dm: direct-mapped, read-only instruction cache.
// Hits return the word combinationally in the request cycle. A miss stalls
// fetch, refills the whole line word 0..WORDS-1 over a req/ack handshake,
// then the same lookup hits. Includes whole-cache flush and a saturating
// miss counter.
//
// Memory handshake: mem_req is raised in REFILL with mem_addr pointing at the
// current word. Both stay stable until the cycle in which mem_ack is high.
// That cycle transfers mem_rdata and completes the request. The next word's
// request follows in the very next cycle, and only one request is ever
// outstanding.
module icache_dm #(
    parameter int LINES = 16,
    parameter int WORDS = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic [31:0]      cpu_addr,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_ready,
    input  logic             flush,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] miss_count,
    output logic             state_dbg
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    // line address = byte address without offset and byte bits
    localparam int LA_W  = 30 - OFF_W;
    localparam int TAG_W = LA_W - IDX_W;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [OFF_W-1:0]   cnt_q, cnt_d;
    logic [LA_W-1:0]    line_q, line_d;
    logic               flush_pend_q, flush_pend_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [CNT_W-1:0]   miss_q, miss_d;

    // storage arrays carry no reset; valid_q alone qualifies their contents
    logic [31:0]        data_q [LINES*WORDS];
    logic [TAG_W-1:0]   tag_q  [LINES];

    logic [OFF_W-1:0]   req_off;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit;
    logic               data_we;
    logic               tag_we;
    logic               unused_addr_bits;

    assign req_off  = cpu_addr[OFF_W+1:2];
    assign req_idx  = cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign req_tag  = cpu_addr[31:OFF_W+IDX_W+2];
    assign fill_idx = line_q[IDX_W-1:0];
    assign fill_tag = line_q[LA_W-1:IDX_W];

    // byte-select bits play no part in an instruction fetch
    assign unused_addr_bits = ^cpu_addr[1:0];

    // lookup is only meaningful while idle; REFILL always reports a stall
    assign hit = (state_q == IDLE) && cpu_req && valid_q[req_idx]
                 && (tag_q[req_idx] == req_tag);

    assign miss_count = miss_q;
    assign state_dbg  = (state_q == REFILL);

    // next-state, refill bookkeeping and all handshake outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        miss_d       = miss_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = 32'h0;
        cpu_ready    = 1'b0;
        cpu_rdata    = 32'h0;

        case (state_q)
            IDLE: begin
                cpu_ready = hit;
                if (hit) begin
                    cpu_rdata = data_q[{req_idx, req_off}];
                end
                if (cpu_req && !hit) begin
                    state_d = REFILL;
                    cnt_d   = '0;
                    line_d  = cpu_addr[31:OFF_W+2];
                    if (miss_q != {CNT_W{1'b1}}) begin
                        miss_d = miss_q + CNT_W'(1);
                    end
                end
                // same-cycle lookup above still saw the old valid bits
                if (flush) begin
                    valid_d = '0;
                end
            end

            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {line_q, cnt_q, 2'b00};
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_ack) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + OFF_W'(1);
                    if (cnt_q == OFF_W'(WORDS - 1)) begin
                        tag_we       = 1'b1;
                        state_d      = IDLE;
                        flush_pend_d = 1'b0;
                        // a flush seen at any point of the refill wins over the fill
                        if (flush_pend_q || flush) begin
                            valid_d = '0;
                        end else begin
                            valid_d[fill_idx] = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // control state; reset abandons any transfer in flight at once
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            line_q       <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            miss_q       <= miss_d;
        end
    end

    // data and tag arrays are written only by the refill engine
    always_ff @(posedge clock) begin
        if (data_we) begin
            data_q[{fill_idx, cnt_q}] <= mem_rdata;
        end
        if (tag_we) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

    // a hit and a memory request are never presented together
    a_no_hit_in_refill: assert property (@(posedge clock) disable iff (!reset)
        !(cpu_ready && mem_req));

    // idle memory port drives a zero address
    a_mem_addr_idle: assert property (@(posedge clock) disable iff (!reset)
        mem_req || (mem_addr == 32'h0));

    // stalled fetch sees a zero instruction word
    a_rdata_idle: assert property (@(posedge clock) disable iff (!reset)
        cpu_ready || (cpu_rdata == 32'h0));

endmodule
